// File: rtl/amm_sim_pkg.sv
// rtl/amm_sim_pkg.sv - shared state type, error codes and LFSR step for the Avalon-MM slave model
package amm_sim_pkg;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_WBURST,
        ST_RBURST
    } amm_state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_RW_BOTH    = 3'd1;
    localparam logic [2:0] ERR_BURST_ZERO = 3'd2;
    localparam logic [2:0] ERR_UNSTABLE   = 3'd3;
    localparam logic [2:0] ERR_REN_IN_WR  = 3'd4;
    localparam logic [2:0] ERR_WEN_IN_RD  = 3'd5;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/amm_be_ram.sv
// rtl/amm_be_ram.sv - single-port RAM with per-byte write enable and registered read
module amm_be_ram #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_W     = 14
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    we,
    input  logic [DATA_WIDTH/8-1:0] be,
    input  logic                    re,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_W];

    // Byte-lane writes; contents are deliberately not reset
    always_ff @(posedge clk) begin
        for (int b = 0; b < DATA_WIDTH/8; b++) begin
            if (we && be[b]) begin
                mem[addr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Registered read; output holds between reads so it can feed the hold-last-value path
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/amm_burst_slave.sv
// rtl/amm_burst_slave.sv - Avalon-MM burst slave memory model with LFSR wait states
module amm_burst_slave
    import amm_sim_pkg::*;
#(
    parameter int          DATA_WIDTH   = 64,
    parameter int          ADDR_WIDTH   = 32,
    parameter int          MEM_AW       = 14,
    parameter int          BURST_W      = 6,
    parameter int          READ_LATENCY = 2,
    parameter int          WAIT_THRESH  = 0,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1,
    parameter int          INIT_CYCLES  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    local_init_done,
    output logic                    amm_wait,
    input  logic [ADDR_WIDTH-1:0]   amm_addr,
    input  logic [BURST_W-1:0]      amm_burstcount,
    input  logic                    amm_ren,
    input  logic                    amm_wen,
    input  logic [DATA_WIDTH-1:0]   amm_wdata,
    input  logic [DATA_WIDTH/8-1:0] amm_byteen,
    output logic                    amm_rvalid,
    output logic [DATA_WIDTH-1:0]   amm_rdata,
    output logic                    protocol_err,
    output logic [2:0]              err_code
);

    localparam logic [8:0]  THRESH    = 9'(WAIT_THRESH);
    localparam logic [15:0] INIT_LAST = 16'(INIT_CYCLES - 1);

    amm_state_t state, state_next;
    logic [15:0]             lfsr, init_cnt;
    logic [MEM_AW-1:0]       base, ram_addr;
    logic [BURST_W-1:0]      count, idx, hold_bc;
    logic [ADDR_WIDTH-1:0]   hold_addr;
    logic                    hold_vld, hold_ren, hold_wen;
    logic [READ_LATENCY-1:0] vld;
    logic [9:0]              thresh_diff;
    logic                    stall, req, last_beat, err_any;
    logic                    accept_w, accept_r, wbeat, ram_we, ram_re;
    logic [2:0]              err_now;
    logic [DATA_WIDTH-1:0]   ram_q;

    // Stall when the low LFSR byte is below the threshold (sign of the difference)
    assign thresh_diff     = {2'b00, lfsr[7:0]} - {1'b0, THRESH};
    assign stall           = thresh_diff[9];
    assign req             = amm_ren | amm_wen;
    assign last_beat       = (idx == count - BURST_W'(1));
    assign local_init_done = (state != ST_INIT);
    assign amm_wait        = (state == ST_IDLE || state == ST_WBURST) ? stall : 1'b1;
    assign amm_rvalid      = vld[READ_LATENCY-1];
    assign err_any         = (err_now != ERR_NONE);
    assign accept_w        = (state == ST_IDLE) && amm_wen && !amm_wait && !err_any;
    assign accept_r        = (state == ST_IDLE) && amm_ren && !amm_wait && !err_any;
    assign wbeat           = (state == ST_WBURST) && amm_wen && !amm_wait && !err_any;

    // Classify this cycle's protocol violation; the offending command or beat is dropped
    always_comb begin
        err_now = ERR_NONE;
        if (state != ST_INIT) begin
            if (amm_ren && amm_wen) begin
                err_now = ERR_RW_BOTH;
            end else if (hold_vld && ((hold_ren && !amm_ren) || (hold_wen && !amm_wen) ||
                         (state == ST_IDLE && (amm_addr != hold_addr || amm_burstcount != hold_bc)))) begin
                err_now = ERR_UNSTABLE;
            end else if (state == ST_IDLE && req && !amm_wait && amm_burstcount == '0) begin
                err_now = ERR_BURST_ZERO;
            end else if (state == ST_WBURST && amm_ren) begin
                err_now = ERR_REN_IN_WR;
            end else if (state == ST_RBURST && amm_wen) begin
                err_now = ERR_WEN_IN_RD;
            end
        end
    end

    // Next-state and RAM port control
    always_comb begin
        state_next = state;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        ram_addr   = base + MEM_AW'(idx);
        case (state)
            ST_INIT: begin
                if (init_cnt == INIT_LAST) state_next = ST_IDLE;
            end
            ST_IDLE: begin
                ram_addr = amm_addr[MEM_AW-1:0];
                ram_we   = accept_w;
                if (accept_w && amm_burstcount > BURST_W'(1)) state_next = ST_WBURST;
                else if (accept_r)                             state_next = ST_RBURST;
            end
            ST_WBURST: begin
                ram_we = wbeat;
                if (wbeat && last_beat) state_next = ST_IDLE;
            end
            ST_RBURST: begin
                ram_re = 1'b1;
                if (last_beat) state_next = ST_IDLE;
            end
            default: state_next = ST_INIT;
        endcase
        if (rst) begin
            ram_we = 1'b0;
            ram_re = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= ST_INIT;
        else     state <= state_next;
    end

    // Burst bookkeeping, wait-state LFSR, sticky error capture and read-valid pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr         <= LFSR_SEED;
            init_cnt     <= '0;
            base         <= '0;
            count        <= '0;
            idx          <= '0;
            hold_vld     <= 1'b0;
            hold_ren     <= 1'b0;
            hold_wen     <= 1'b0;
            hold_addr    <= '0;
            hold_bc      <= '0;
            protocol_err <= 1'b0;
            err_code     <= ERR_NONE;
            vld          <= '0;
        end else begin
            lfsr <= lfsr_next(lfsr);
            if (state == ST_INIT) init_cnt <= init_cnt + 16'd1;
            if (accept_w || accept_r) begin
                base  <= amm_addr[MEM_AW-1:0];
                count <= amm_burstcount;
                idx   <= accept_w ? BURST_W'(1) : '0;
            end else if (wbeat || state == ST_RBURST) begin
                idx <= idx + BURST_W'(1);
            end
            if (err_any && !protocol_err) begin
                protocol_err <= 1'b1;
                err_code     <= err_now;
            end
            hold_vld  <= (state == ST_IDLE || state == ST_WBURST) && req && amm_wait;
            hold_ren  <= amm_ren;
            hold_wen  <= amm_wen;
            hold_addr <= amm_addr;
            hold_bc   <= amm_burstcount;
            vld[0]    <= ram_re;
            for (int j = 1; j < READ_LATENCY; j++) vld[j] <= vld[j-1];
        end
    end

    amm_be_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (MEM_AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (ram_we),
        .be    (amm_byteen),
        .re    (ram_re),
        .addr  (ram_addr),
        .wdata (amm_wdata),
        .rdata (ram_q)
    );

    generate
        if (READ_LATENCY == 1) begin : g_direct
            assign amm_rdata = ram_q;
        end else begin : g_pipe
            logic [DATA_WIDTH-1:0] dat [READ_LATENCY-1];
            // Extra latency stages; each holds its value while its input is not valid
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < READ_LATENCY-1; j++) dat[j] <= '0;
                end else begin
                    if (vld[0]) dat[0] <= ram_q;
                    for (int j = 1; j < READ_LATENCY-1; j++) begin
                        if (vld[j]) dat[j] <= dat[j-1];
                    end
                end
            end
            assign amm_rdata = dat[READ_LATENCY-2];
        end
    endgenerate

endmodule

// File: tb/tb_amm_burst_slave.sv
// tb/tb_amm_burst_slave.sv - scoreboard bench for amm_burst_slave
module tb_amm_burst_slave;

    localparam int RL = 2;

    typedef struct {
        logic [63:0] d;
        int          c;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] addr  [2];
    logic [5:0]  bc    [2];
    logic        ren   [2];
    logic        wen   [2];
    logic [63:0] wdata [2];
    logic [7:0]  be    [2];
    logic        done  [2];
    logic        amw   [2];
    logic        rvalid[2];
    logic [63:0] rdata [2];
    logic        perr  [2];
    logic [2:0]  code  [2];

    exp_t        q0[$];
    exp_t        q1[$];
    logic [63:0] m1   [16];
    logic [63:0] wbuf [64];
    logic [7:0]  bbuf [64];
    logic [63:0] ebuf [64];
    int n_cmp = 0;
    int n_bad = 0;

    amm_burst_slave dut0 (
        .clk(clk), .rst(rst), .local_init_done(done[0]), .amm_wait(amw[0]),
        .amm_addr(addr[0]), .amm_burstcount(bc[0]), .amm_ren(ren[0]), .amm_wen(wen[0]),
        .amm_wdata(wdata[0]), .amm_byteen(be[0]), .amm_rvalid(rvalid[0]), .amm_rdata(rdata[0]),
        .protocol_err(perr[0]), .err_code(code[0])
    );

    amm_burst_slave #(.MEM_AW(4), .WAIT_THRESH(128)) dut1 (
        .clk(clk), .rst(rst), .local_init_done(done[1]), .amm_wait(amw[1]),
        .amm_addr(addr[1]), .amm_burstcount(bc[1]), .amm_ren(ren[1]), .amm_wen(wen[1]),
        .amm_wdata(wdata[1]), .amm_byteen(be[1]), .amm_rvalid(rvalid[1]), .amm_rdata(rdata[1]),
        .protocol_err(perr[1]), .err_code(code[1])
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    task automatic do_beat(input int d, input logic r, input logic w, input logic [31:0] a,
                           input logic [5:0] n, input logic [63:0] wd, input logic [7:0] b,
                           output int k);
        int guard = 0;
        @(negedge clk);
        ren[d] = r; wen[d] = w; addr[d] = a; bc[d] = n; wdata[d] = wd; be[d] = b;
        while (amw[d] && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout dut%0d: waitrequest still 1 after %0d cycles, required 0", d, guard);
        end
        k = cyc + 1;
        @(posedge clk);
    endtask

    task automatic write_burst(input int d, input logic [31:0] a, input logic [5:0] n);
        int k;
        for (int i = 0; i < int'(n); i++) begin
            do_beat(d, 1'b0, 1'b1, a, n, wbuf[i], bbuf[i], k);
            if (d == 1) begin
                for (int b = 0; b < 8; b++)
                    if (bbuf[i][b]) m1[4'(a + 32'(i))][8*b +: 8] = wbuf[i][8*b +: 8];
            end
        end
        @(negedge clk);
        wen[d] = 1'b0;
    endtask

    task automatic read_burst(input int d, input logic [31:0] a, input logic [5:0] n);
        int   k;
        exp_t e;
        do_beat(d, 1'b1, 1'b0, a, n, 64'h0, 8'h00, k);
        for (int i = 0; i < int'(n); i++) begin
            e.d = ebuf[i];
            e.c = k + RL + i;
            if (d == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        ren[d] = 1'b0;
        repeat (int'(n)) @(posedge clk);
    endtask

    task automatic check_rv(input int d);
        exp_t        e;
        logic [63:0] act;
        int          sz;
        act = rdata[d];
        sz  = (d == 0) ? q0.size() : q1.size();
        if (sz == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rvalid_unexpected dut%0d: got beat %h, required none", d, act);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else        e = q1.pop_front();
        chk($sformatf("rdata_dut%0d", d), act, e.d);
        chk($sformatf("rvalid_cycle_dut%0d", d), 64'(cyc), 64'(e.c));
    endtask

    // Monitors: every presented beat is popped and compared
    always @(negedge clk) if (rvalid[0] === 1'b1) check_rv(0);
    always @(negedge clk) if (rvalid[1] === 1'b1) check_rv(1);

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [5:0]  n;
        int          k, g;
        for (int d = 0; d < 2; d++) begin
            ren[d] = 0; wen[d] = 0; addr[d] = 0; bc[d] = 1; wdata[d] = 0; be[d] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_init_done", 64'(done[0]), 64'd0);
        chk("rst_wait", 64'(amw[0]), 64'd1);
        chk("rst_rvalid", 64'(rvalid[0]), 64'd0);
        chk("rst_rdata", rdata[0], 64'd0);
        chk("rst_perr", 64'(perr[0]), 64'd0);
        chk("rst_code", 64'(code[0]), 64'd0);
        chk("rst_wait_dut1", 64'(amw[1]), 64'd1);
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            @(negedge clk);
            if (c == 15) chk("init_done_c15", 64'(done[0]), 64'd0);
            if (c == 16) begin
                chk("init_done_c16", 64'(done[0]), 64'd1);
                chk("init_wait_c16", 64'(amw[0]), 64'd0);
                chk("init_done_dut1_c16", 64'(done[1]), 64'd1);
            end
        end

        // Write burst then read burst
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 64'hA0 + 64'(i); bbuf[i] = 8'hFF; ebuf[i] = 64'hA0 + 64'(i);
        end
        write_burst(0, 32'h10, 6'd4);
        read_burst(0, 32'h10, 6'd4);
        // Upper address bits ignored
        ebuf[0] = 64'hA1; ebuf[1] = 64'hA2;
        read_burst(0, 32'h0010_0011, 6'd2);

        // Byte enables
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF; bbuf[0] = 8'hFF;
        write_burst(0, 32'h5, 6'd1);
        wbuf[0] = 64'h0; bbuf[0] = 8'h0F;
        write_burst(0, 32'h5, 6'd1);
        ebuf[0] = 64'hFFFF_FFFF_0000_0000;
        read_burst(0, 32'h5, 6'd1);

        // Fill the 16-word memory, then a wrapping burst
        for (int i = 0; i < 16; i++) begin
            wbuf[i] = {$urandom, $urandom}; bbuf[i] = 8'hFF;
        end
        write_burst(1, 32'h0, 6'd16);
        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 64'hB0 + 64'(i); bbuf[i] = 8'hFF;
        end
        write_burst(1, 32'd14, 6'd4);
        ebuf[0] = 64'hB2;
        read_burst(1, 32'd0, 6'd1);
        ebuf[0] = 64'hB3;
        read_burst(1, 32'd1, 6'd1);
        ebuf[0] = 64'hB0; ebuf[1] = 64'hB1; ebuf[2] = 64'hB2; ebuf[3] = 64'hB3;
        read_burst(1, 32'd14, 6'd4);

        // Random bursts against the stalling instance
        for (int t = 0; t < 200; t++) begin
            a = $urandom;
            n = 6'($urandom_range(1, 8));
            if ($urandom_range(0, 1) == 1) begin
                for (int i = 0; i < int'(n); i++) begin
                    wbuf[i] = {$urandom, $urandom}; bbuf[i] = 8'($urandom);
                end
                write_burst(1, a, n);
            end else begin
                for (int i = 0; i < int'(n); i++) ebuf[i] = m1[4'(a + 32'(i))];
                read_burst(1, a, n);
            end
        end
        repeat (6) @(negedge clk);
        chk("random_perr_dut1", 64'(perr[1]), 64'd0);
        chk("directed_perr_dut0", 64'(perr[0]), 64'd0);

        // Simultaneous read and write
        @(negedge clk);
        ren[0] = 1; wen[0] = 1; addr[0] = 32'h10; bc[0] = 1;
        @(negedge clk);
        ren[0] = 0; wen[0] = 0;
        chk("err_flag_rw", 64'(perr[0]), 64'd1);
        chk("err_code_rw", 64'(code[0]), 64'd1);
        // Zero burstcount write is dropped and does not replace the first code
        do_beat(0, 1'b0, 1'b1, 32'h10, 6'd0, 64'h0, 8'hFF, k);
        @(negedge clk);
        wen[0] = 0;
        chk("err_code_sticky", 64'(code[0]), 64'd1);
        ebuf[0] = 64'hA0;
        read_burst(0, 32'h10, 6'd1);

        // Address change while stalled
        g = 0;
        @(negedge clk);
        while (!amw[1] && g < 100) begin
            @(negedge clk);
            g++;
        end
        ren[1] = 1; addr[1] = 32'd3; bc[1] = 1;
        @(negedge clk);
        addr[1] = 32'd4;
        @(negedge clk);
        ren[1] = 0;
        chk("err_flag_unstable", 64'(perr[1]), 64'd1);
        chk("err_code_unstable", 64'(code[1]), 64'd3);

        // Reset clears errors; RAM contents survive
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_perr0", 64'(perr[0]), 64'd0);
        chk("rst2_code0", 64'(code[0]), 64'd0);
        chk("rst2_perr1", 64'(perr[1]), 64'd0);
        chk("rst2_code1", 64'(code[1]), 64'd0);
        chk("rst2_done", 64'(done[0]), 64'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) ebuf[i] = 64'hA0 + 64'(i);
        read_burst(0, 32'h10, 6'd4);

        repeat (10) @(negedge clk);
        chk("drain_q0", 64'(q0.size()), 64'd0);
        chk("drain_q1", 64'(q1.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
